// File: rtl/mac_dot_pipe.sv
// Pipelined multi-lane signed dot-product MAC: lane products are summed and accumulated across a burst.
// When the burst ends, the accumulator is rounded, arithmetically shifted and saturated to OUT_W.
module mac_dot_pipe #(
    parameter int DATA_W  = 16,
    parameter int LANES   = 4,
    parameter int ACC_W   = 48,
    parameter int OUT_W   = 36,
    parameter int SHIFT_W = 6
) (
    input  logic                      system_clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      sclr,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic                      subtract,
    input  logic [LANES*DATA_W-1:0]   a,
    input  logic [LANES*DATA_W-1:0]   b,
    input  logic signed [ACC_W-1:0]   bias,
    input  logic [SHIFT_W-1:0]        shift,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out,
    output logic                      out_sat,
    output logic signed [ACC_W-1:0]   pcout
);

    logic [LANES*DATA_W-1:0]   a1, b1;
    logic signed [ACC_W-1:0]   bias1, bias2;
    logic [SHIFT_W-1:0]        shift1, shift2, shift3;
    logic                      v1, f1, l1, s1;
    logic                      v2, f2, l2, s2;
    logic                      emit3;
    logic signed [2*DATA_W-1:0] prod2  [LANES];
    logic signed [2*DATA_W-1:0] prod_c [LANES];
    logic signed [ACC_W-1:0]   acc, psum, base, acc_nxt;
    logic signed [ACC_W:0]     rbit, rnd, shifted, sat_max, sat_min;
    logic signed [OUT_W-1:0]   res;
    logic                      clip;

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_c[i] = (2*DATA_W)'($signed(a1[i*DATA_W +: DATA_W]))
                      * (2*DATA_W)'($signed(b1[i*DATA_W +: DATA_W]));
        end
    end

    // Using the S3-aligned first flag keeps back-to-back bursts from mixing.
    always_comb begin
        psum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            psum = psum + ACC_W'(prod2[i]);
        end
        base    = f2 ? bias2 : acc;
        acc_nxt = s2 ? (base - psum) : (base + psum);
    end

    // One extra bit of headroom so the rounding add can never wrap.
    always_comb begin
        rbit = '0;
        if (shift3 != '0) begin
            rbit = {{ACC_W{1'b0}}, 1'b1} << (shift3 - SHIFT_W'(1));
        end
        rnd     = {acc[ACC_W-1], acc} + rbit;
        shifted = rnd >>> shift3;
        sat_max = '0;
        sat_max[OUT_W-2:0] = '1;
        sat_min = '1;
        sat_min[OUT_W-2:0] = '0;
        clip = 1'b0;
        res  = shifted[OUT_W-1:0];
        if (shifted > sat_max) begin
            res  = sat_max[OUT_W-1:0];
            clip = 1'b1;
        end else if (shifted < sat_min) begin
            res  = sat_min[OUT_W-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            a1     <= '0;
            b1     <= '0;
            bias1  <= '0;
            shift1 <= '0;
            f1     <= 1'b0;
            l1     <= 1'b0;
            s1     <= 1'b0;
            bias2  <= '0;
            shift2 <= '0;
            f2     <= 1'b0;
            l2     <= 1'b0;
            s2     <= 1'b0;
            shift3 <= '0;
            for (int unsigned i = 0; i < LANES; i++) prod2[i] <= '0;
        end else if (ce) begin
            a1     <= a;
            b1     <= b;
            bias1  <= bias;
            shift1 <= shift;
            f1     <= in_first;
            l1     <= in_last;
            s1     <= subtract;
            bias2  <= bias1;
            shift2 <= shift1;
            f2     <= f1;
            l2     <= l1;
            s2     <= s1;
            shift3 <= shift2;
            for (int unsigned i = 0; i < LANES; i++) prod2[i] <= prod_c[i];
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            emit3     <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_sat   <= 1'b0;
        end else if (sclr) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            emit3     <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            v1        <= in_valid;
            v2        <= v1;
            emit3     <= v2 & l2;
            if (v2) acc <= acc_nxt;
            out_valid <= emit3;
            if (emit3) begin
                out     <= res;
                out_sat <= clip;
            end
        end
    end

    assign pcout = acc;

endmodule

// File: doc/mac_dot_pipe.md
# mac_dot_pipe

Parametrised, pipelined dot-product multiply-accumulate unit. It is the multi-lane successor to the single DSP multiply-adder: it takes LANES signed operand pairs per beat, sums their products, and accumulates across beats with optional bias and subtract. When a burst ends, it emits a rounded, right-shifted, saturated result. It sits inside the convolution/FC processing element, between the weight/activation buffers and the output quantiser, and exposes a raw accumulator cascade port for chaining.

## Interface
- DATA_W, 16, signed width of each a/b operand
- LANES, 4, operand pairs per beat (≥1)
- ACC_W, 48, signed accumulator and cascade width
- OUT_W, 36, signed output width (OUT_W ≤ ACC_W)
- SHIFT_W, 6, width of the shift control
- system_clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  pipeline enable; 0 freezes every register
- sclr  in  1  synchronous clear; takes priority over ce
- in_valid  in  1  beat present on a/b
- in_first  in  1  beat starts a new accumulation (loads bias)
- in_last  in  1  beat ends accumulation (result emitted)
- subtract  in  1  beat's product sum is subtracted instead of added
- a  in  LANES*DATA_W  packed signed operands, lane 0 in LSBs
- b  in  LANES*DATA_W  packed signed operands
- bias  in  ACC_W  signed initial value, sampled with in_first beat
- shift  in  SHIFT_W  output arithmetic right shift, sampled with in_last beat
- out_valid  out  1  one-cycle result strobe
- out  out  OUT_W  rounded, shifted, saturated result
- out_sat  out  1  result was clipped (valid with out_valid)
- pcout  out  ACC_W  current accumulator register (cascade)

## Operation
- Four register stages, all advancing only when ce=1:
  - S1: capture a, b, bias, shift, and the flags (valid, first, last, subtract).
  - S2: LANES full-precision signed products (2*DATA_W bits), registered.
  - S3: products sign-extended to ACC_W and summed to psum. Accumulator update:
    - first=1: acc ← bias ± psum
    - otherwise: acc ← acc ± psum
    - "−" applies when subtract=1.
  - S4: on a last beat, r = acc + (shift>0 ? 1<<(shift−1) : 0), then arithmetic shift r >>> shift, then saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. out_sat=1 if clipped.
- Invalid beats (valid=0 in S3) leave acc unchanged.
- A beat with first=1 and last=1 is a complete single-beat result.
- A beat without first after reset or sclr accumulates onto acc=0.
- Accumulator overflow wraps in two's complement, with no flag. The rounding add is done at ACC_W+1 bits, so it cannot wrap.
- pcout = acc register at all times.
- out and out_sat hold their last value until the next emitted result.
- sclr=1 at an edge: all stage valids, acc, out, out_sat, pcout, and out_valid go to 0. Beats in flight are discarded.
- rst_n=0: the same clear, applied asynchronously. This is legal mid-burst; the next burst must begin with in_first.

## Timing
- Reset values: out_valid=0, out=0, out_sat=0, pcout=0.
- Latency: a beat accepted at edge k (in_valid=1, ce=1):
  - updates acc/pcout at edge k+2;
  - if in_last, drives out_valid=1 with the result after edge k+3, high for exactly one cycle (while ce=1).
- Throughput: one beat per cycle with no bubbles. A new in_first may immediately follow an in_last. The S3 accumulator uses the S3 first flag, so back-to-back bursts never mix.
- ce=0: all registers hold, including out_valid (a strobe present when ce drops stays asserted until ce returns). Cycle counts stretch by exactly the stalled cycles.
- sclr and ce=0 together: sclr wins.
- No backpressure: the downstream must accept every out_valid.

## Test plan
- Single beat, LANES=4: lane0 a=−10, b=−5 (other lanes 0), bias=−20, first=last=1, shift=0, subtract=0 → out=30 four edges later, out_sat=0, pcout=30.
- Subtract: lane0 a=10, b=−5, bias=−10, subtract=1, first=last=1 → out=40. Then lane0 a=−8, b=2, bias=−30 on the next cycle → out=−46 one cycle after the first result.
- Three-beat burst, all lanes a=1, b=2 (psum=8), bias=5, shift=2 → pcout 13, 21, 29; out=(29+2)>>>2=7. Negative check: acc=−7, shift=2 → out=−2.
- Saturation: bias=2^40, first=last=1, zero operands, shift=0 → out=2^35−1, out_sat=1. With bias=−2^40 → out=−2^35, out_sat=1.
- Stall: hold ce=0 for 3 cycles mid-burst → result identical, out_valid delayed by exactly 3 cycles, and no duplicate strobe.
- Clear/reset: assert sclr (then separately rst_n=0) during beat 2 of a 3-beat burst → no out_valid for that burst, pcout=0. A following first=last beat with bias=−20, a·b=50 → out=30.
